rob_ctrl: RTL
=============

// Module: rob_ctrl
// PURPOSE
//  In-order reorder-buffer control between decode and rename/dispatch. Allocates one
//  ROB id per decoded instruction (dec_rob_id), records out-of-order completion, and
//  retires entries in program order (commit_e_/com_rob_id). A completed entry flagged
//  with an exception is not retired; the block raises flush_ and clears all state.
// PARAMETERS
//  ROB_DEPTH  16               number of entries, power of two, >= 2
//  ROB        $clog2(ROB_DEPTH) entry index width (derived, do not override)
// PORTS
//  clk         in   1        clock
//  reset_      in   1        asynchronous reset, active-low
//  dec_e_      in   1        allocate request, active-low; ignored while rob_full=1
//  dec_invalid in   1        decoded instruction is illegal
//  dec_rd      in   RegFile_t destination register of allocating instruction
//  dec_rob_id  out  ROB      id granted to the current allocate (= tail index)
//  rob_full    out  1        no entry available this cycle; decode must stall
//  exe_e_      in   1        completion report, active-low
//  exe_rob_id  in   ROB      completing entry
//  exe_exp     in   1        completing instruction raised exception/mispredict
//  commit_e_   out  1        head entry retires this cycle, active-low
//  com_rob_id  out  ROB      retiring entry id (= head index)
//  com_rd      out  RegFile_t retiring destination register
//  flush_      out  1        pipeline flush, active-low, one cycle
// BEHAVIOUR
//  - State: per-entry valid, done, exp, rd; head/tail pointers of ROB+1 bits (MSB =
//    wrap bit). empty: head==tail; full: index equal, wrap bits differ.
//  - Reset: valid/done/exp=0, head=tail=0; outputs: dec_rob_id=0, rob_full=0,
//    commit_e_=1, com_rob_id=0, com_rd=0, flush_=1.
//  - Allocate: !dec_e_ && !rob_full at edge -> entry[tail]={valid=1, rd=dec_rd,
//    done=dec_invalid, exp=dec_invalid}; tail++. dec_rob_id = tail[ROB-1:0] (comb).
//  - Complete: !exe_e_ && valid[exe_rob_id] -> done=1, exp=exe_exp at edge. Report to
//    an invalid entry: dropped, no state change. Second report to same entry: last wins.
//  - Commit (combinational from registered state): commit_e_=0 iff valid[head] &&
//    done[head] && !exp[head] && flush_==1. Edge: valid[head]=0, head++.
//    com_rob_id=head index, com_rd=rd[head] always driven.
//  - Exception: valid[head] && done[head] && exp[head] -> commit_e_ stays 1; at edge
//    all valid/done/exp cleared, head=tail=0, flush_ register <= 0 for exactly one
//    cycle. While flush_==0: rob_full forced 1, exe_e_ ignored, no commit.
//  - Same cycle: allocate + commit both apply (count unchanged). Completion of head
//    is visible to commit the next cycle (no bypass). rob_full uses current-cycle
//    state only: a full ROB does not accept an allocate in the cycle it commits.
//  - Allocate to the slot being freed is impossible (full blocks it); pointer wrap is
//    natural modulo 2^(ROB+1).
//  - Reset mid-operation: all state returns to reset values asynchronously.
//  - Throughput: 1 allocate + 1 completion + 1 commit per cycle.
// STRUCTURE
//  - Shared header rob.svh: RobEntry_t {valid, done, exp, RegFile_t rd}, RobPtr_t
//    ({wrap, idx}). RegFile_t/TYPE_* come from regfile.svh, ROB_DEPTH from cpu_config.svh.
//  - One sub-module: rob_ptr (ROB+1-bit wrap pointer, inc_/clr_ inputs), used for head
//    and tail. Entry array stays inline.
// TESTING  (ROB_DEPTH=4)
//  - Reset, 4 allocates (rd=GPR x1..x4) -> dec_rob_id 0,1,2,3; rob_full=1 after 4th;
//    5th request ignored, tail unchanged.
//  - Complete ids 2,1,0 in that order -> commits ids 0,1,2 on consecutive cycles with
//    com_rd x1,x2,x3; id 3 not committed until completed.
//  - Full ROB, head done, allocate same cycle -> no allocate; next cycle allocate
//    granted id 0 (wrap) while commit of id 1 proceeds.
//  - Complete id 1 with exe_exp=1, id 0 normal -> commit id 0, then flush_=0 one cycle,
//    commit_e_=1, rob_full=1 during flush; afterwards dec_rob_id=0, empty.
//  - Allocate with dec_invalid=1 at head -> no commit, flush_ pulse next cycle.
//  - Completion to unallocated id 3 -> ignored; async reset asserted mid-stream ->
//    all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/rob_ctrl_pkg.sv
// Shared types for the reorder-buffer control slice.
// Register-file descriptor, ROB entry layout and default depth.
package rob_ctrl_pkg;

    localparam int ROB_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        TYPE_NONE,
        TYPE_GPR,
        TYPE_FPR,
        TYPE_CSR
    } RegType_t;

    typedef struct packed {
        RegType_t   rtype;
        logic [4:0] idx;
    } RegFile_t;

    typedef struct packed {
        logic     valid;
        logic     done;
        logic     exp;
        RegFile_t rd;
    } RobEntry_t;

endpackage

// File: rtl/rob_ctrl_if.sv
// Decode / execute / commit bundle between the pipeline and the ROB.
// master = pipeline side, slave = ROB side.
interface rob_ctrl_if
    import rob_ctrl_pkg::*;
#(
    parameter  int ROB_DEPTH = ROB_DEPTH_DEF,
    localparam int ROB       = $clog2(ROB_DEPTH)
);

    logic           dec_e_;
    logic           dec_invalid;
    RegFile_t       dec_rd;
    logic [ROB-1:0] dec_rob_id;
    logic           rob_full;

    logic           exe_e_;
    logic [ROB-1:0] exe_rob_id;
    logic           exe_exp;

    logic           commit_e_;
    logic [ROB-1:0] com_rob_id;
    RegFile_t       com_rd;
    logic           flush_;

    modport master (
        output dec_e_, dec_invalid, dec_rd,
        output exe_e_, exe_rob_id, exe_exp,
        input  dec_rob_id, rob_full,
        input  commit_e_, com_rob_id, com_rd, flush_
    );

    modport slave (
        input  dec_e_, dec_invalid, dec_rd,
        input  exe_e_, exe_rob_id, exe_exp,
        output dec_rob_id, rob_full,
        output commit_e_, com_rob_id, com_rd, flush_
    );

endinterface

// File: rtl/rob_ptr.sv
// Wrap-bit pointer for ROB head/tail.
// Clear has priority over increment.
module rob_ptr #(
    parameter int W = 4
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       inc_,
    input  logic       clr_,
    output logic [W:0] ptr
);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ptr <= '0;
        end else if (!clr_) begin
            ptr <= '0;
        end else if (!inc_) begin
            ptr <= ptr + (W+1)'(1);
        end
    end

endmodule

// File: rtl/rob_ctrl.sv
// In-order reorder-buffer control: allocate at tail, complete
// out of order, retire at head, flush on a faulting head entry.
module rob_ctrl
    import rob_ctrl_pkg::*;
#(
    parameter  int ROB_DEPTH = ROB_DEPTH_DEF,
    localparam int ROB       = $clog2(ROB_DEPTH)
) (
    input  logic       clk,
    input  logic       reset_,
    rob_ctrl_if.slave  rob
);

    typedef struct packed {
        logic           wrap;
        logic [ROB-1:0] idx;
    } RobPtr_t;

    RobEntry_t ent [ROB_DEPTH];
    RobEntry_t hd;
    RobPtr_t   head;
    RobPtr_t   tail;

    logic flush_q;
    logic full;
    logic full_w;
    logic alloc;
    logic commit;
    logic exc;
    logic cpl;

    assign hd     = ent[head.idx];
    assign full   = (head.idx == tail.idx) && (head.wrap != tail.wrap);
    assign full_w = full | ~flush_q;

    assign alloc  = ~rob.dec_e_ & ~full_w;
    assign commit = hd.valid & hd.done & ~hd.exp & flush_q;
    assign exc    = hd.valid & hd.done & hd.exp & flush_q;
    assign cpl    = ~rob.exe_e_ & flush_q & ent[rob.exe_rob_id].valid;

    rob_ptr #(.W(ROB)) u_head (
        .clk    (clk),
        .reset_ (reset_),
        .inc_   (~commit),
        .clr_   (~exc),
        .ptr    (head)
    );

    rob_ptr #(.W(ROB)) u_tail (
        .clk    (clk),
        .reset_ (reset_),
        .inc_   (~alloc),
        .clr_   (~exc),
        .ptr    (tail)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            flush_q <= 1'b1;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            flush_q <= ~exc;
            if (exc) begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    ent[i].valid <= 1'b0;
                    ent[i].done  <= 1'b0;
                    ent[i].exp   <= 1'b0;
                end
            end else begin
                if (cpl) begin
                    ent[rob.exe_rob_id].done <= 1'b1;
                    ent[rob.exe_rob_id].exp  <= rob.exe_exp;
                end
                if (commit) begin
                    ent[head.idx].valid <= 1'b0;
                end
                // Illegal instructions enter already done+faulting
                if (alloc) begin
                    ent[tail.idx].valid <= 1'b1;
                    ent[tail.idx].done  <= rob.dec_invalid;
                    ent[tail.idx].exp   <= rob.dec_invalid;
                    ent[tail.idx].rd    <= rob.dec_rd;
                end
            end
        end
    end

    assign rob.dec_rob_id = tail.idx;
    assign rob.rob_full   = full_w;
    assign rob.commit_e_  = ~commit;
    assign rob.com_rob_id = head.idx;
    assign rob.com_rd     = hd.rd;
    assign rob.flush_     = flush_q;

endmodule
